// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared types for the hazard/forwarding controller: forward selects, pipeline slot record, FSM states.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       we;
        logic       ld;
    } slot_t;

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } state_e;

    localparam logic [4:0] REG_ZERO   = 5'd0;
    localparam slot_t      SLOT_EMPTY = '0;

endpackage

// File: rtl/hazard_forward_ctrl_fwd_src_select.sv
// Picks the bypass source for one EX source index from the MEM and WB slots; x0 never forwards.
module fwd_src_select
    import hazard_pkg::*;
(
    input  slot_t      mem_slot_i,
    input  slot_t      wb_slot_i,
    input  logic [4:0] src_i,
    output fwd_sel_e   sel_o
);

    logic mem_hit;
    logic wb_hit;

    // A load in MEM has no data yet, so only ALU results bypass from MEM.
    assign mem_hit = mem_slot_i.valid && mem_slot_i.we && !mem_slot_i.ld &&
                     (mem_slot_i.rd != REG_ZERO) && (mem_slot_i.rd == src_i);
    assign wb_hit  = wb_slot_i.valid && wb_slot_i.we &&
                     (wb_slot_i.rd != REG_ZERO) && (wb_slot_i.rd == src_i);

    always_comb begin
        sel_o = FWD_RF;
        if (mem_hit) begin
            sel_o = FWD_MEM;
        end else if (wb_hit) begin
            sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard/forwarding controller: EX/MEM/WB destination tracking, bypass selects, load-use stall and memory-wait freeze.
// Optional HAZARD_PERF_EN adds stall/bubble/freeze event counters.
module hazard_forward_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  id_rd,
    input  logic        id_reg_write,
    input  logic        id_is_load,
    input  logic [4:0]  ex_rs1,
    input  logic [4:0]  ex_rs2,
    input  logic [3:0]  ex_wmask,
    input  logic        mem_ready,
    output logic        stall,
    output logic        bubble,
    output logic        freeze,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic [1:0]  st_fwd,
    output logic        mem_err,
`ifdef HAZARD_PERF_EN
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_bubbles,
    output logic [31:0] perf_freeze_cycles,
`endif
    output state_e      dbg_state
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(MEM_TIMEOUT);

    slot_t            ex_q, mem_q, wb_q;
    slot_t            ex_d;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_err_q, mem_err_d;
    logic             mwait;
    logic             load_use;
    fwd_sel_e         sel_a, sel_b, sel_st;

    fwd_src_select u_fwd_a (.mem_slot_i(mem_q), .wb_slot_i(wb_q), .src_i(ex_rs1), .sel_o(sel_a));
    fwd_src_select u_fwd_b (.mem_slot_i(mem_q), .wb_slot_i(wb_q), .src_i(ex_rs2), .sel_o(sel_b));
    fwd_src_select u_fwd_st(.mem_slot_i(mem_q), .wb_slot_i(wb_q), .src_i(ex_rs2), .sel_o(sel_st));

    assign mwait    = mem_q.valid && mem_q.ld && !mem_ready;
    assign load_use = id_valid && ex_q.valid && ex_q.ld && ex_q.we && (ex_q.rd != REG_ZERO) &&
                      ((id_use_rs1 && (id_rs1 == ex_q.rd)) || (id_use_rs2 && (id_rs2 == ex_q.rd)));

    // Freeze wins over load-use: the bubble would be lost while every slot holds.
    assign freeze    = mwait;
    assign stall     = mwait || load_use;
    assign bubble    = load_use && !mwait;
    assign fwd_a     = sel_a;
    assign fwd_b     = sel_b;
    assign st_fwd    = (ex_wmask != 4'b0000) ? sel_st : FWD_RF;
    assign mem_err   = mem_err_q;
    assign dbg_state = state_q;

    always_comb begin
        ex_d = SLOT_EMPTY;
        if (id_valid && !bubble) begin
            ex_d = '{valid: 1'b1, rd: id_rd, we: id_reg_write, ld: id_is_load};
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_err_d = mem_err_q;
        case (state_q)
            RUN: begin
                if (mwait) begin
                    state_d = WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            WAIT: begin
                if (mwait) begin
                    if (cnt_q != TIMEOUT_C) cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
        if (cnt_d == TIMEOUT_C) mem_err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q      <= SLOT_EMPTY;
            mem_q     <= SLOT_EMPTY;
            wb_q      <= SLOT_EMPTY;
            state_q   <= RUN;
            cnt_q     <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mem_err_q <= mem_err_d;
            if (!freeze) begin
                wb_q  <= mem_q;
                mem_q <= ex_q;
                ex_q  <= ex_d;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cycles  <= '0;
            perf_bubbles       <= '0;
            perf_freeze_cycles <= '0;
        end else begin
            if (stall)  perf_stall_cycles  <= perf_stall_cycles + 32'd1;
            if (bubble) perf_bubbles       <= perf_bubbles + 32'd1;
            if (freeze) perf_freeze_cycles <= perf_freeze_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed bench for hazard_forward_ctrl: forwarding, x0 guard, load-use, memory wait, timeout, reset mid-wait.
module tb_hazard_forward_ctrl;
    import hazard_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_is_load;
    logic [4:0]  id_rs1, id_rs2, id_rd, ex_rs1, ex_rs2;
    logic [3:0]  ex_wmask;
    logic        mem_ready;
    logic        stall, bubble, freeze, mem_err;
    logic [1:0]  fwd_a, fwd_b, st_fwd;
    state_e      dbg_state;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_cycles, perf_bubbles, perf_freeze_cycles;
`endif

    int checks   = 0;
    int failures = 0;

    hazard_forward_ctrl #(.MEM_TIMEOUT(16), .CNT_W(5)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_wmask(ex_wmask), .mem_ready(mem_ready),
        .stall(stall), .bubble(bubble), .freeze(freeze),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .st_fwd(st_fwd), .mem_err(mem_err),
`ifdef HAZARD_PERF_EN
        .perf_stall_cycles(perf_stall_cycles), .perf_bubbles(perf_bubbles),
        .perf_freeze_cycles(perf_freeze_cycles),
`endif
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        id_rd = 0; id_reg_write = 0; id_is_load = 0;
        ex_rs1 = 0; ex_rs2 = 0; ex_wmask = 0; mem_ready = 1;
    endtask

    task automatic issue(input logic [4:0] rd, input logic we, input logic ld);
        id_valid = 1; id_rd = rd; id_reg_write = we; id_is_load = ld;
        id_use_rs1 = 0; id_use_rs2 = 0; id_rs1 = 0; id_rs2 = 0;
    endtask

    task automatic flush();
        idle();
        repeat (3) tick();
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_stall"}, 32'(stall), 0);
        chk({tag, "_bubble"}, 32'(bubble), 0);
        chk({tag, "_freeze"}, 32'(freeze), 0);
        chk({tag, "_fwd_a"}, 32'(fwd_a), 0);
        chk({tag, "_fwd_b"}, 32'(fwd_b), 0);
        chk({tag, "_st_fwd"}, 32'(st_fwd), 0);
        chk({tag, "_mem_err"}, 32'(mem_err), 0);
        chk({tag, "_state"}, 32'(dbg_state), 32'(RUN));
`ifdef HAZARD_PERF_EN
        chk({tag, "_perf_stall"}, perf_stall_cycles, 0);
        chk({tag, "_perf_bubble"}, perf_bubbles, 0);
        chk({tag, "_perf_freeze"}, perf_freeze_cycles, 0);
`endif
    endtask

    initial begin
        idle();
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        #1 chk_quiet("reset");

        // ALU chain: add x5, then two followers reading x5 in EX
        issue(5'd5, 1, 0); tick();
        issue(5'd6, 1, 0); tick();
        issue(5'd8, 1, 0); ex_rs1 = 5; #1;
        chk("alu_mem_fwd_a", 32'(fwd_a), 1);
        tick();
        id_valid = 0; ex_rs1 = 5; ex_rs2 = 6; #1;
        chk("alu_wb_fwd_a", 32'(fwd_a), 2);
        chk("alu_mem_fwd_b", 32'(fwd_b), 1);
        chk("alu_no_stall", 32'(stall), 0);

        // MEM wins over WB when both hold the same rd
        flush();
        issue(5'd9, 1, 0); tick();
        issue(5'd9, 1, 0); tick();
        id_valid = 0; tick();
        ex_rs1 = 9; #1;
        chk("prio_mem_over_wb", 32'(fwd_a), 1);

        // x0 guard
        flush();
        issue(5'd0, 1, 0); tick();
        id_valid = 0; tick();
        ex_rs1 = 0; ex_rs2 = 0; #1;
        chk("x0_mem_fwd_a", 32'(fwd_a), 0);
        chk("x0_mem_fwd_b", 32'(fwd_b), 0);
        tick();
        chk("x0_wb_fwd_a", 32'(fwd_a), 0);
        chk("x0_wb_fwd_b", 32'(fwd_b), 0);

        // Load-use: lw x7 in EX, consumer reads x7 via rs2
        flush();
        issue(5'd7, 1, 1); tick();
        issue(5'd9, 1, 0); id_use_rs2 = 1; id_rs2 = 7; #1;
        chk("lu_stall", 32'(stall), 1);
        chk("lu_bubble", 32'(bubble), 1);
        chk("lu_freeze", 32'(freeze), 0);
        tick();
        ex_rs1 = 7; #1;
        chk("lu_after_stall", 32'(stall), 0);
        chk("lu_after_bubble", 32'(bubble), 0);
        chk("lu_load_in_mem_no_fwd", 32'(fwd_a), 0);
        tick();
        id_valid = 0; ex_rs1 = 0; ex_rs2 = 7; ex_wmask = 4'b1111; #1;
        chk("lu_wb_fwd_b", 32'(fwd_b), 2);
        chk("lu_st_fwd_store", 32'(st_fwd), 2);
        ex_wmask = 4'b0000; #1;
        chk("lu_st_fwd_nostore", 32'(st_fwd), 0);
        chk("lu_fwd_b_nostore", 32'(fwd_b), 2);

        // Load-use with id_valid low raises nothing
        flush();
        issue(5'd14, 1, 1); tick();
        id_valid = 0; id_use_rs1 = 1; id_rs1 = 14; #1;
        chk("novalid_stall", 32'(stall), 0);
        chk("novalid_bubble", 32'(bubble), 0);
        id_valid = 1; #1;
        chk("valid_stall", 32'(stall), 1);

        // Memory wait: 3 cycles of mem_ready low then high
        flush();
        issue(5'd10, 1, 1); tick();
        issue(5'd11, 1, 0); tick();
        id_valid = 0; mem_ready = 0; ex_rs2 = 10; #1;
        chk("mw_freeze_1", 32'(freeze), 1);
        chk("mw_stall_1", 32'(stall), 1);
        chk("mw_bubble_1", 32'(bubble), 0);
        chk("mw_state_1", 32'(dbg_state), 32'(RUN));
        tick();
        chk("mw_freeze_2", 32'(freeze), 1);
        chk("mw_state_2", 32'(dbg_state), 32'(WAIT));
        chk("mw_slots_held", 32'(fwd_b), 0);
        tick();
        chk("mw_freeze_3", 32'(freeze), 1);
        chk("mw_stall_3", 32'(stall), 1);
        tick();
        mem_ready = 1; #1;
        chk("mw_ready_freeze", 32'(freeze), 0);
        chk("mw_ready_stall", 32'(stall), 0);
        tick();
        ex_rs1 = 11; #1;
        chk("mw_adv_wb_load", 32'(fwd_b), 2);
        chk("mw_adv_mem_alu", 32'(fwd_a), 1);
        chk("mw_state_run", 32'(dbg_state), 32'(RUN));
        chk("mw_no_err", 32'(mem_err), 0);

        // Timeout with back-to-back loads; freeze suppresses the load-use bubble
        flush();
        issue(5'd12, 1, 1); tick();
        issue(5'd13, 1, 1); tick();
        issue(5'd15, 1, 0); id_use_rs1 = 1; id_rs1 = 13; mem_ready = 0; #1;
        chk("to_freeze", 32'(freeze), 1);
        chk("to_bubble_suppressed", 32'(bubble), 0);
        chk("to_stall", 32'(stall), 1);
        repeat (15) tick();
        chk("to_no_err_at_15", 32'(mem_err), 0);
        tick();
        chk("to_err_after_16", 32'(mem_err), 1);
        repeat (3) tick();
        chk("to_still_frozen", 32'(freeze), 1);
        mem_ready = 1; #1;
        chk("to_ready_freeze", 32'(freeze), 0);
        chk("to_ready_bubble", 32'(bubble), 1);
        tick();
        chk("to_err_sticky", 32'(mem_err), 1);
        chk("to_bubble_once", 32'(bubble), 0);
        chk("to_state_run", 32'(dbg_state), 32'(RUN));

        // Reset in the middle of a wait
        id_valid = 0; id_use_rs1 = 0; mem_ready = 0; #1;
        chk("rst_pre_freeze", 32'(freeze), 1);
        tick();
        chk("rst_pre_state", 32'(dbg_state), 32'(WAIT));
        rst = 1;
        tick();
        rst = 0;
        idle();
        #1 chk_quiet("rst_mid_wait");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
